// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard/interrupt sequencer.
//   - PCSrc encodings seen on the ID and EX stage PC-source fields
//   - FSM state encoding
//   - is_jump(): decodes the unconditional-redirect PCSrc values
package hazard_ctrl_pkg;

  localparam logic [2:0] PCSRC_NEXT = 3'd0;  // PC+4
  localparam logic [2:0] PCSRC_BR   = 3'd1;  // conditional branch
  localparam logic [2:0] PCSRC_J    = 3'd2;  // J / JAL
  localparam logic [2:0] PCSRC_JR   = 3'd3;  // JR / JALR
  localparam logic [2:0] PCSRC_IRQ  = 3'd4;  // interrupt vector

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_STALL      = 3'd1,
    ST_IRQ_WAIT   = 3'd2,
    ST_IRQ_TAKE   = 3'd3,
    ST_IRQ_MASKED = 3'd4
  } state_t;

  // True for the PC sources that redirect fetch unconditionally from ID.
  function automatic logic is_jump(input logic [2:0] pcsrc);
    return (pcsrc == PCSRC_J) || (pcsrc == PCSRC_JR);
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// load_use_detect: combinational load-use hazard detector.
//   mem_rd : instruction in EX is a load
//   rt_ex  : destination register of the load in EX
//   rs_id  : first source register of the instruction in ID
//   rt_id  : second source register of the instruction in ID
//   lu     : ID consumes the load result before it is available
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       mem_rd,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  output logic       lu
);

  // $zero never carries a real dependency, so a load targeting r0 never stalls.
  assign lu = mem_rd && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and interrupt sequencer for the five-stage core.
//   Parameter STALL_CYCLES : bubbles inserted per load-use hazard (1..7)
//   clk, reset             : rising-edge clock, asynchronous active-low reset
//   Rs_IF_ID, Rt_IF_ID     : source registers of the instruction in ID
//   Rt_ID_EX, MemRd_ID_EX  : destination / load flag of the instruction in EX
//   PCSrc_ID, PCSrc_ID_EX  : PC source of the instructions in ID and EX
//   branch_taken_EX        : branch condition evaluated true in EX
//   irq, irq_clear         : interrupt request level, ERET re-enable pulse
//   PC_write, IF_ID_write  : register enables
//   IF_ID_flush, ID_EX_flush : pipeline register clears
//   irq_take               : select interrupt vector and latch EPC
//   busy                   : sequencer is not in RUN
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_IF_ID,
  input  logic [4:0] Rt_IF_ID,
  input  logic [4:0] Rt_ID_EX,
  input  logic       MemRd_ID_EX,
  input  logic [2:0] PCSrc_ID,
  input  logic [2:0] PCSrc_ID_EX,
  input  logic       branch_taken_EX,
  input  logic       irq,
  input  logic       irq_clear,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       irq_take,
  output logic       busy
);

  localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
  localparam logic       STALL_MULTI  = (STALL_CYCLES > 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       lu_s;
  logic       br_s;
  logic       jp_s;
  logic       stall_s;
  logic       take_ok_s;

  load_use_detect u_lu (
    .mem_rd (MemRd_ID_EX),
    .rt_ex  (Rt_ID_EX),
    .rs_id  (Rs_IF_ID),
    .rt_id  (Rt_IF_ID),
    .lu     (lu_s)
  );

  assign br_s    = (PCSrc_ID_EX == PCSRC_BR) && branch_taken_EX;
  assign jp_s    = is_jump(PCSrc_ID);
  // A non-zero counter means extra bubbles are still owed, in any state.
  assign stall_s = (cnt_r != 3'd0);
  // Take only on a clean boundary so EPC never lands in a branch/jump shadow.
  assign take_ok_s = irq && (PCSrc_ID_EX == PCSRC_NEXT) && !br_s && !lu_s
                     && !jp_s && !stall_s;

  // Next-state and stall-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (br_s) begin
      // The redirect squashes whatever was stalled; a pending interrupt survives.
      cnt_nxt_s = 3'd0;
      case (state_r)
        ST_RUN:        state_nxt_s = irq ? ST_IRQ_WAIT : ST_RUN;
        ST_STALL:      state_nxt_s = ST_RUN;
        ST_IRQ_WAIT:   state_nxt_s = irq ? ST_IRQ_WAIT : ST_RUN;
        ST_IRQ_TAKE:   state_nxt_s = ST_IRQ_WAIT;
        ST_IRQ_MASKED: state_nxt_s = irq_clear ? ST_RUN : ST_IRQ_MASKED;
        default:       state_nxt_s = ST_RUN;
      endcase
    end else if (state_r == ST_IRQ_TAKE) begin
      cnt_nxt_s   = 3'd0;
      state_nxt_s = ST_IRQ_MASKED;
    end else begin
      if (stall_s) begin
        cnt_nxt_s = cnt_r - 3'd1;
      end else if (lu_s && STALL_MULTI) begin
        cnt_nxt_s = STALL_RELOAD;
      end else begin
        cnt_nxt_s = 3'd0;
      end
      case (state_r)
        ST_RUN: begin
          if (lu_s && STALL_MULTI) begin
            state_nxt_s = ST_STALL;
          end else if (irq) begin
            state_nxt_s = ST_IRQ_WAIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STALL: state_nxt_s = (cnt_nxt_s == 3'd0) ? ST_RUN : ST_STALL;
        ST_IRQ_WAIT: begin
          // Leaving the interrupt path mid-stall must still finish the bubbles.
          if (!irq) begin
            state_nxt_s = (cnt_nxt_s != 3'd0) ? ST_STALL : ST_RUN;
          end else if (take_ok_s) begin
            state_nxt_s = ST_IRQ_TAKE;
          end else begin
            state_nxt_s = ST_IRQ_WAIT;
          end
        end
        ST_IRQ_MASKED: begin
          if (irq_clear) begin
            state_nxt_s = (cnt_nxt_s != 3'd0) ? ST_STALL : ST_RUN;
          end else begin
            state_nxt_s = ST_IRQ_MASKED;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

  // State and stall-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Zero-latency pipeline control decode in priority order br > take > stall > jump.
  always_comb begin
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    irq_take    = 1'b0;
    if (!reset) begin
      // Defaults are forced while reset is held, whatever the inputs show.
      irq_take = 1'b0;
    end else if (br_s) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (state_r == ST_IRQ_TAKE) begin
      irq_take    = 1'b1;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (stall_s || lu_s) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end else if (jp_s) begin
      IF_ID_flush = 1'b1;
    end else begin
      irq_take = 1'b0;
    end
  end

  assign busy = (state_r != ST_RUN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench driving two hazard_ctrl instances
// (STALL_CYCLES = 1 and 3) with shared inputs and hand-computed expectations.
// Outputs are packed {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, irq_take, busy}.
module tb_hazard_ctrl;

  localparam logic [5:0] DEF  = 6'b110000;  // defaults, RUN
  localparam logic [5:0] STL  = 6'b000100;  // stall, RUN
  localparam logic [5:0] STLB = 6'b000101;  // stall, busy
  localparam logic [5:0] BR   = 6'b111100;  // branch flush, RUN
  localparam logic [5:0] BRB  = 6'b111101;  // branch flush, busy
  localparam logic [5:0] JP   = 6'b111000;  // jump flush
  localparam logic [5:0] WB   = 6'b110001;  // defaults, busy
  localparam logic [5:0] TAKE = 6'b111111;  // interrupt take

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs_IF_ID, Rt_IF_ID, Rt_ID_EX;
  logic       MemRd_ID_EX;
  logic [2:0] PCSrc_ID, PCSrc_ID_EX;
  logic       branch_taken_EX, irq, irq_clear;
  logic       pcw1, ifw1, iff1, idf1, take1, busy1;
  logic       pcw3, ifw3, iff3, idf3, take3, busy3;
  logic [5:0] o1, o3;
  int         n_tests = 0;
  int         n_fail  = 0;

  assign o1 = {pcw1, ifw1, iff1, idf1, take1, busy1};
  assign o3 = {pcw3, ifw3, iff3, idf3, take3, busy3};

  always #5 clk = ~clk;

  hazard_ctrl dut1 (
    .clk(clk), .reset(reset), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .Rt_ID_EX(Rt_ID_EX), .MemRd_ID_EX(MemRd_ID_EX), .PCSrc_ID(PCSrc_ID),
    .PCSrc_ID_EX(PCSrc_ID_EX), .branch_taken_EX(branch_taken_EX), .irq(irq),
    .irq_clear(irq_clear), .PC_write(pcw1), .IF_ID_write(ifw1),
    .IF_ID_flush(iff1), .ID_EX_flush(idf1), .irq_take(take1), .busy(busy1)
  );

  hazard_ctrl #(.STALL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .Rt_ID_EX(Rt_ID_EX), .MemRd_ID_EX(MemRd_ID_EX), .PCSrc_ID(PCSrc_ID),
    .PCSrc_ID_EX(PCSrc_ID_EX), .branch_taken_EX(branch_taken_EX), .irq(irq),
    .irq_clear(irq_clear), .PC_write(pcw3), .IF_ID_write(ifw3),
    .IF_ID_flush(iff3), .ID_EX_flush(idf3), .irq_take(take3), .busy(busy3)
  );

  task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_both(input string tag, input logic [5:0] e1, input logic [5:0] e3);
    @(negedge clk);
    check_val({tag, "/sc1"}, o1, e1);
    check_val({tag, "/sc3"}, o3, e3);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0; Rt_ID_EX = 5'd0; MemRd_ID_EX = 1'b0;
    PCSrc_ID = 3'd0; PCSrc_ID_EX = 3'd0; branch_taken_EX = 1'b0;
    irq = 1'b0; irq_clear = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rt_ex, input logic [4:0] rs, input logic [4:0] rt);
    MemRd_ID_EX = 1'b1; Rt_ID_EX = rt_ex; Rs_IF_ID = rs; Rt_IF_ID = rt;
  endtask

  initial begin
    // Reset: defaults even with a hazard on the inputs
    reset = 1'b0;
    clear_inputs();
    #3;
    check_val("rst_idle/sc1", o1, DEF);
    check_val("rst_idle/sc3", o3, DEF);
    set_lu(5'd8, 5'd8, 5'd0);
    #1;
    check_val("rst_lu/sc1", o1, DEF);
    check_val("rst_lu/sc3", o3, DEF);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Load-use: 1 bubble on sc1, 3 bubbles (busy for 2) on sc3
    set_lu(5'd8, 5'd8, 5'd0);
    expect_both("lu", STL, STL);  tick(); clear_inputs();
    expect_both("lu_c2", DEF, STLB); tick();
    expect_both("lu_c3", DEF, STLB); tick();
    expect_both("lu_done", DEF, DEF); tick();

    // No hazard: load to $zero, non-load match; hazard on Rt path
    set_lu(5'd0, 5'd0, 5'd0);
    expect_both("lu_zero", DEF, DEF); tick();
    clear_inputs(); Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
    expect_both("no_load", DEF, DEF); tick();
    set_lu(5'd5, 5'd3, 5'd5);
    expect_both("lu_rt", STL, STL); tick(); clear_inputs();
    expect_both("lu_rt_c2", DEF, STLB); tick();
    expect_both("lu_rt_c3", DEF, STLB); tick();

    // Branch in the second stall cycle of sc3
    set_lu(5'd9, 5'd9, 5'd0);
    expect_both("br_pre", STL, STL); tick(); clear_inputs();
    PCSrc_ID_EX = 3'd1; branch_taken_EX = 1'b1;
    expect_both("br_in_stall", BR, BRB); tick(); clear_inputs();
    expect_both("br_after", DEF, DEF); tick();
    PCSrc_ID_EX = 3'd1;
    expect_both("br_not_taken", DEF, DEF); tick(); clear_inputs();

    // Jumps, and their priority against lu and br
    PCSrc_ID = 3'd2;
    expect_both("jp_j", JP, JP); tick();
    PCSrc_ID = 3'd3;
    expect_both("jp_jr", JP, JP); tick();
    PCSrc_ID = 3'd2; PCSrc_ID_EX = 3'd1; branch_taken_EX = 1'b1;
    expect_both("br_vs_jp", BR, BR); tick(); clear_inputs();
    PCSrc_ID = 3'd2; set_lu(5'd4, 5'd4, 5'd0);
    expect_both("lu_vs_jp", STL, STL); tick(); clear_inputs();
    expect_both("lu_vs_jp_c2", DEF, STLB); tick();
    expect_both("lu_vs_jp_c3", DEF, STLB); tick();

    // Interrupt held off by a branch in EX, then taken once
    irq = 1'b1; PCSrc_ID_EX = 3'd1;
    expect_both("irq_run", DEF, DEF); tick();
    expect_both("irq_held", WB, WB); tick();
    PCSrc_ID_EX = 3'd0;
    expect_both("irq_clean", WB, WB); tick();
    expect_both("irq_take", TAKE, TAKE); tick();
    expect_both("irq_masked", WB, WB); tick();
    expect_both("irq_masked2", WB, WB); tick();
    irq_clear = 1'b1;
    expect_both("irq_clr", WB, WB); tick();
    irq_clear = 1'b0;
    expect_both("irq_rerun", DEF, DEF); tick();
    expect_both("irq_rewait", WB, WB);

    // Reset asserted mid-IRQ_WAIT
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_mid/sc1", o1, DEF);
    check_val("rst_mid/sc3", o3, DEF);
    @(posedge clk);
    #1;
    check_val("rst_hold/sc1", o1, DEF);
    check_val("rst_hold/sc3", o3, DEF);
    irq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    expect_both("rst_release", DEF, DEF); tick();
    expect_both("rst_no_take", DEF, DEF); tick();

    // irq dropped while waiting returns to RUN without a take
    irq = 1'b1;
    expect_both("drop_run", DEF, DEF); tick();
    irq = 1'b0;
    expect_both("drop_wait", WB, WB); tick();
    expect_both("drop_done", DEF, DEF); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and interrupt sequencer for the five-stage CPU_Pipeline core. It sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable and flush controls, plus the PC write-enable. It detects load-use hazards and taken-branch/jump redirects, and takes external interrupts at a safe instruction boundary. Stall length is set by a cycle counter, so the block can also serve slower data memories.

## Interface
- `STALL_CYCLES`, default 1: number of bubbles inserted per load-use hazard (range 1–7).
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `Rs_IF_ID`, `Rt_IF_ID` input 5: source registers of the instruction in ID.
- `Rt_ID_EX` input 5: destination register of the instruction in EX.
- `MemRd_ID_EX` input 1: the instruction in EX is a load.
- `PCSrc_ID` input 3: decoded PC source of the instruction in ID. Encoding: 0 = PC+4, 1 = branch, 2 = J/JAL, 3 = JR/JALR.
- `PCSrc_ID_EX` input 3: PC source of the instruction in EX.
- `branch_taken_EX` input 1: ALU branch condition is true in EX.
- `irq` input 1: level-sensitive interrupt request, already synchronised.
- `irq_clear` input 1: one-cycle pulse from the ERET path that re-enables interrupts.
- `PC_write` output 1: PC register enable.
- `IF_ID_write` output 1: IF/ID register enable.
- `IF_ID_flush` output 1: IF/ID register clear.
- `ID_EX_flush` output 1: ID/EX register clear (`ID_EX_flush`).
- `irq_take` output 1: forces PCSrc = 4 (interrupt vector) and latches EPC for one cycle.
- `busy` output 1: FSM state is not RUN.

## Operation
- **FSM states:** RUN, STALL, IRQ_WAIT, IRQ_TAKE, IRQ_MASKED. The state and a 3-bit stall counter are registered. All outputs are Mealy, decoded combinationally from state and inputs, and take effect at the next edge.
- **Load-use hazard (`lu`):** `MemRd_ID_EX` is high, `Rt_ID_EX` is non-zero, and `Rt_ID_EX` equals `Rs_IF_ID` or `Rt_IF_ID`.
- **Branch redirect (`br`):** `PCSrc_ID_EX` is 1 and `branch_taken_EX` is high.
- **Jump redirect (`jp`):** `PCSrc_ID` is 2 or 3.
- **Default outputs:** `PC_write` = 1, `IF_ID_write` = 1, both flushes = 0, `irq_take` = 0.
- **Priority each cycle:** `br` > IRQ_TAKE > `lu`/STALL > `jp`.
- **`br`:** assert `IF_ID_flush` and `ID_EX_flush`. If the state is STALL, return to RUN and clear the counter. A pending IRQ_WAIT is kept.
- **RUN with `lu`:**
  - Drive `PC_write` = 0, `IF_ID_write` = 0, `ID_EX_flush` = 1.
  - If `STALL_CYCLES` > 1, move to STALL with the counter set to `STALL_CYCLES`−1. Otherwise stay in RUN.
- **STALL:** hold the same outputs and decrement the counter. When the counter reaches 1, the next state is RUN.
- **`jp` (not stalled):** assert `IF_ID_flush` only.
- **Entering IRQ_WAIT:** RUN with `irq` high moves to IRQ_WAIT. Normal hazard handling continues while waiting.
- **IRQ_WAIT to IRQ_TAKE:** move when all of the following hold in the same cycle:
  - `PCSrc_ID_EX` is 0;
  - no `br`;
  - no `lu`;
  - `PCSrc_ID` is not 2 or 3.
  
  This keeps EPC off any branch or jump shadow.
- **IRQ_TAKE (exactly 1 cycle):**
  - Outputs: `irq_take` = 1, `IF_ID_flush` = 1, `ID_EX_flush` = 1, `PC_write` = 1.
  - Next state is IRQ_MASKED.
- **IRQ_MASKED:** `irq` is ignored and normal hazard handling applies. `irq_clear` moves the state to RUN.
- **`irq` deasserted in IRQ_WAIT:** return to RUN with no take.
- **`busy`:** high in every state except RUN.

## Timing
- **Reset:** while `reset` is low, the state is RUN and the counter is 0. Outputs are the defaults: `PC_write` = 1, `IF_ID_write` = 1, flushes = 0, `irq_take` = 0, `busy` = 0.
- **Reset mid-STALL or mid-IRQ:** return to RUN immediately. There is no pending take afterwards.
- **Output latency:** hazard outputs appear in the same cycle as the detecting inputs, with zero latency. State changes take one clock.
- **Load-use penalty:** exactly `STALL_CYCLES` bubbles.
- **Branch penalty:** 2 flushed slots.
- **Jump penalty:** 1 flushed slot.
- **Interrupt latency:** one cycle after the IRQ_WAIT conditions are first met.
- **`irq` and `irq_clear` in the same cycle while in IRQ_MASKED:** go to RUN. `irq` is sampled again the following cycle.

## Structure
- **Shared package:** PCSrc encodings (`PCSRC_NEXT`, `PCSRC_BR`, `PCSRC_J`, `PCSRC_JR`, `PCSRC_IRQ`) and FSM state constants.
- **Sub-module `load_use_detect`:** purely combinational, producing `lu`.
- **Top level:** the FSM, the counter and output decode stay here.

## Test plan
- **Load-use, `STALL_CYCLES` = 1:** `MemRd_ID_EX` = 1, `Rt_ID_EX` = 8, `Rs_IF_ID` = 8 → for one cycle `PC_write` = 0, `IF_ID_write` = 0, `ID_EX_flush` = 1; the next cycle shows the defaults.
- **Load-use to `$zero`, and `STALL_CYCLES` = 3:**
  - `Rt_ID_EX` = 0 → no stall.
  - `STALL_CYCLES` = 3 → exactly 3 stall cycles and `busy` = 1 for 2 cycles.
- **Branch during STALL (`STALL_CYCLES` = 3):** `br` in the second stall cycle → both flushes = 1 and `PC_write` = 1 that cycle; the state is RUN next.
- **Jump in ID:** `PCSrc_ID` = 2 → `IF_ID_flush` = 1, `ID_EX_flush` = 0.
- **Interrupt with branch in EX:** raise `irq` while `PCSrc_ID_EX` = 1 → `irq_take` is held off. With clean stages the next cycle → `irq_take` pulses once with both flushes. `irq` kept high → no second take until `irq_clear`.
- **Reset mid-IRQ_WAIT:** assert `reset` low mid-IRQ_WAIT → all outputs are the defaults immediately; `busy` = 0 after release.
